// File: rtl/mod_counter_pkg.sv
// mod_counter_pkg: shared mode, direction and prescaler-width constants for mod_counter
package mod_counter_pkg;
    localparam int   CNT_WRAP = 0;
    localparam int   CNT_SAT  = 1;
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DN   = 1'b0;
    localparam int   PS_W     = 16;
endpackage

// File: rtl/mod_counter_if.sv
// mod_counter_if: control and status bundle between a counter user (master) and mod_counter (slave)
interface mod_counter_if #(parameter int WIDTH = 8);
    logic             en;
    logic             up_dn;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] cnt;
    logic             evt;
    logic             at_bound;
    modport master (output en, up_dn, clr, load, load_val, input cnt, evt, at_bound);
    modport slave  (input en, up_dn, clr, load, load_val, output cnt, evt, at_bound);
endinterface

// File: rtl/mod_counter_tick_gen.sv
// tick_gen: prescaler that pulses tick on every DIV-th enabled cycle
module tick_gen
    import mod_counter_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic restart,
    output logic tick
);
    if (DIV == 1) begin : g_pass
        logic w_unused;
        assign w_unused = clk ^ rst ^ restart;
        assign tick = en;
    end else begin : g_div
        logic [PS_W-1:0] r_ps;
        assign tick = en && r_ps == PS_W'(DIV - 1);
        always_ff @(posedge clk)
            if (rst || restart) r_ps <= '0;
            else if (en) r_ps <= tick ? '0 : r_ps + PS_W'(1);
    end
endmodule

// File: rtl/mod_counter.sv
// mod_counter: modulo up/down counter with prescaler, clamp-on-load, wrap/saturate and event pulse
module mod_counter
    import mod_counter_pkg::*;
#(
    parameter int              WIDTH    = 8,
    parameter longint unsigned MAX      = (64'd1 << WIDTH) - 64'd1,
    parameter int              PRESCALE = 1,
    parameter int              SATURATE = CNT_WRAP
) (
    input  logic        clk,
    input  logic        rst,
    mod_counter_if.slave bus
);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("mod_counter: WIDTH must be 1..32");
    end
    if (MAX < 64'd1 || MAX > (64'd1 << WIDTH) - 64'd1) begin : g_bad_max
        $error("mod_counter: MAX must be 1..2**WIDTH-1");
    end
    if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
        $error("mod_counter: PRESCALE must be 1..65535");
    end
    logic [WIDTH-1:0] r_cnt;
    logic             r_evt;
    logic             w_tick;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_bound;
    logic [WIDTH-1:0] w_step_val;
    logic [WIDTH-1:0] w_load_val;
    tick_gen #(.DIV(PRESCALE)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .en      (bus.en),
        .restart (bus.clr | bus.load),
        .tick    (w_tick)
    );
    assign w_at_max  = r_cnt == MAX_W;
    assign w_at_zero = r_cnt == '0;
    assign w_bound   = (bus.up_dn == DIR_UP && w_at_max) || (bus.up_dn == DIR_DN && w_at_zero);
    // Bound is checked before the add/subtract, so MAX = all-ones never overflows.
    assign w_step_val = bus.up_dn == DIR_UP
        ? (w_at_max ? (SATURATE == CNT_SAT ? MAX_W : '0) : r_cnt + WIDTH'(1))
        : (w_at_zero ? (SATURATE == CNT_SAT ? '0 : MAX_W) : r_cnt - WIDTH'(1));
    assign w_load_val = bus.load_val > MAX_W ? MAX_W : bus.load_val;
    always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
            r_cnt <= '0;
            r_evt <= 1'b0;
        end else if (bus.load) begin
            r_cnt <= w_load_val;
            r_evt <= 1'b0;
        end else if (w_tick) begin
            r_cnt <= w_step_val;
            r_evt <= w_bound;
        end else begin
            r_evt <= 1'b0;
        end
    end
    assign bus.cnt      = r_cnt;
    assign bus.evt      = r_evt;
    assign bus.at_bound = w_bound;
endmodule

// File: doc/mod_counter.md
# mod_counter

Parametrised modulo up/down counter, successor to the team's fixed 4-bit free-running wrap counter. Adds configurable width and terminal value, direction control, enable, synchronous clear and load, wrap or saturate mode, a built-in prescaler, and a registered wrap/limit event pulse. Intended as the general-purpose counting primitive for timers, address generators and event counters across the design.

## Interface

Parameters:
- WIDTH, 8: counter width in bits, 1 to 32.
- MAX, 2**WIDTH-1: terminal value; count range is 0 to MAX. Requires 1 <= MAX <= 2**WIDTH-1.
- PRESCALE, 1: a step occurs every PRESCALE enabled cycles; 1 to 65535.
- SATURATE, 0: 0 = wrap at bounds; 1 = hold at bounds.

Ports:
- clk  in  1  rising-edge clock; the block's only clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  count enable; gates the prescaler and steps.
- up_dn  in  1  direction: 1 = up, 0 = down; sampled at each step.
- clr  in  1  synchronous clear to 0.
- load  in  1  synchronous load of load_val.
- load_val  in  WIDTH  value for load.
- cnt  out  WIDTH  current count, registered.
- evt  out  1  registered one-cycle pulse on a wrap (SATURATE=0) or a blocked step at a bound (SATURATE=1).
- at_bound  out  1  combinational: (up_dn && cnt==MAX) || (!up_dn && cnt==0).

## Operation

- Per-edge priority: rst > clr > load > step > hold.
- rst: cnt=0, evt=0, prescaler count=0.
- clr: cnt=0, prescaler=0, evt=0.
- load: cnt = min(load_val, MAX); prescaler=0; evt=0. An out-of-range load_val is clamped, never wrapped.
- Prescaler: internal counter 0..PRESCALE-1; advances only when en=1 and no clr/load; asserts tick on the cycle its value is PRESCALE-1, then returns to 0. With en=0 it holds. With PRESCALE=1, tick = en.
- Step (en && tick):
  - Up, cnt<MAX: cnt+1. Up, cnt==MAX: wrap to 0 with evt=1 (SATURATE=0), or hold at MAX with evt=1 (SATURATE=1).
  - Down, cnt>0: cnt-1. Down, cnt==0: wrap to MAX with evt=1, or hold at 0 with evt=1 (saturate).
- Arithmetic is performed at WIDTH bits, with the bound compare done before the increment or decrement, so no overflow occurs even when MAX = 2**WIDTH-1.
- evt is 0 on every cycle not described above.
- A direction change takes effect at the next step. The prescaler phase is unaffected.

## Timing

- Reset values: cnt=0, evt=0. at_bound follows cnt and up_dn combinationally; it equals !up_dn after reset.
- Step latency: cnt updates on the edge where en && tick is sampled high. evt is high in the cycle after that edge, aligned with the new cnt.
- With en held high, steps occur every PRESCALE cycles. The first step comes PRESCALE cycles after rst/clr/load deassert.
- clr or load asserted together with a would-be wrap suppresses evt.
- rst mid-count (including mid-prescale) discards all state within one edge.

## Structure

- Shared package mod_counter_pkg holds:
  - the SATURATE mode constants CNT_WRAP=0 and CNT_SAT=1;
  - direction constants DIR_UP=1 and DIR_DN=0;
  - the PRESCALE width constant (16 bits).
- Sub-module tick_gen(clk, rst, en, restart, tick), parameter DIV, implements the prescaler; restart = clr|load. When DIV=1 it reduces to tick=en with no register.
- The top level holds the count register, bound compare, clamp and evt register.
- Elaboration-time assertions check the MAX and PRESCALE ranges.

## Test plan

- WIDTH=4, MAX=15, PRESCALE=1, SATURATE=0; en=1, up for 17 cycles -> cnt 0..15,0,1; evt high only in the cycle cnt shows 0 after 15.
- WIDTH=4, MAX=9, down from reset -> first step: cnt 0->9 with evt=1; then 8,7,...
- SATURATE=1, MAX=5, up 8 steps -> cnt stops at 5; evt high on each of the 3 blocked steps; at_bound=1 from the cnt=5 cycle onward.
- PRESCALE=3, en=1 -> cnt increments every 3rd cycle; drop en for 2 cycles mid-phase -> phase is held and resumes.
- MAX=9, load with load_val=12 -> cnt=9. Assert clr together with load -> cnt=0. Assert load together with a wrap step -> loaded value, evt=0.
- rst asserted while cnt=7 and prescaler mid-phase -> next cycle cnt=0, evt=0; with en=1, the first step occurs PRESCALE cycles after rst drops.
